// File: rtl/sram_write_buffer_pkg.sv
// Shared helpers for the SRAM write buffer.
//   ring_offset: distance from base to idx around a ring of 'depth' slots,
//   used both for the occupancy mask and for age-ordered snoop scanning.
package sram_write_buffer_pkg;

  function automatic int unsigned ring_offset(input int unsigned idx,
                                              input int unsigned base,
                                              input int unsigned depth);
    return (idx + depth - base) % depth;
  endfunction

endpackage

// File: rtl/sram_wb_snoop.sv
// Snoop lookup for the SRAM write buffer.
// Compares snoop_addr_i against every occupied entry and returns the data of
// the youngest match (the one nearest newest_idx_i).
// Ports:
//   occ_mask_i   - bit i set when entry i holds pending data
//   addr_flat_i  - entry addresses, entry i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   data_flat_i  - entry data, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   newest_idx_i - index of the most recently written entry
//   snoop_addr_i - lookup address
//   hit_o/data_o - match flag and youngest matching data (0 on miss)
module sram_wb_snoop
  import sram_write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            occ_mask_i,
  input  logic [DEPTH*ADDR_WIDTH-1:0] addr_flat_i,
  input  logic [DEPTH*DATA_WIDTH-1:0] data_flat_i,
  input  logic [PW-1:0]               newest_idx_i,
  input  logic [ADDR_WIDTH-1:0]       snoop_addr_i,
  output logic                        hit_o,
  output logic [DATA_WIDTH-1:0]       data_o
);

  logic                  hit_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [PW-1:0]         idx_s;
  logic                  match_s;

  // Scan oldest-to-youngest so the last match seen (the youngest) wins.
  always_comb begin
    hit_s   = 1'b0;
    data_s  = '0;
    idx_s   = '0;
    match_s = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx_s   = PW'(ring_offset(32'(newest_idx_i), 32'(k), 32'(DEPTH)));
      match_s = occ_mask_i[idx_s] &&
                (addr_flat_i[idx_s*ADDR_WIDTH +: ADDR_WIDTH] == snoop_addr_i);
      hit_s   = hit_s | match_s;
      data_s  = match_s ? data_flat_i[idx_s*DATA_WIDTH +: DATA_WIDTH] : data_s;
    end
  end

  assign hit_o  = hit_s;
  assign data_o = data_s;

endmodule

// File: rtl/sram_write_buffer.sv
// In-order write buffer between the CPU store path and the SRAM arbiter.
// Back-to-back writes to the newest entry's address merge into that entry.
// Ports:
//   clk, reset (sync, active-low)
//   wr_addr/wr_data/wr_en         - push request
//   full/almost_full/level        - occupancy, from registered pointers only
//   overflow                      - sticky, a push was dropped
//   rd_addr/rd_data/rd_valid/rd_en - head entry and pop
//   snoop_addr/snoop_hit/snoop_data - combinational lookup of pending data
module sram_write_buffer
  import sram_write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12,
  parameter int COALESCE    = 1,
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [PW:0]           level,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  output logic                  snoop_hit,
  output logic [DATA_WIDTH-1:0] snoop_data
);

  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;

  logic [PW:0]   level_s;
  logic [PW-1:0] wr_idx_s, rd_idx_s, newest_idx_s;
  logic          full_s, valid_s, pop_s, coalesce_s, push_s, drop_s;

  logic [DEPTH-1:0]            occ_mask_s;
  logic [DEPTH*ADDR_WIDTH-1:0] addr_flat_s;
  logic [DEPTH*DATA_WIDTH-1:0] data_flat_s;

  assign level_s      = wr_ptr_q - rd_ptr_q;
  assign wr_idx_s     = wr_ptr_q[PW-1:0];
  assign rd_idx_s     = rd_ptr_q[PW-1:0];
  assign newest_idx_s = wr_idx_s - PW'(1);
  assign full_s       = (level_s == (PW+1)'(DEPTH));
  assign valid_s      = (level_s != '0);
  assign pop_s        = rd_en && valid_s;

  // Write-action resolution: coalesce beats push beats drop. Merging into a
  // sole entry that is being popped would lose the write, so that case pushes.
  always_comb begin
    coalesce_s = (COALESCE == 1) && wr_en && valid_s &&
                 (wr_addr == addr_mem_q[newest_idx_s]) &&
                 !((level_s == (PW+1)'(1)) && rd_en);
    push_s     = wr_en && !coalesce_s && !full_s;
    drop_s     = wr_en && !coalesce_s && full_s;
  end

  // Next-state for pointers and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Pointer and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[wr_idx_s] <= wr_addr;
      data_mem_q[wr_idx_s] <= wr_data;
    end else if (coalesce_s) begin
      data_mem_q[newest_idx_s] <= wr_data;
    end
  end

  // Occupancy mask and flattened entry views for the snoop comparator.
  always_comb begin
    occ_mask_s  = '0;
    addr_flat_s = '0;
    data_flat_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_mask_s[i] = (ring_offset(32'(i), 32'(rd_idx_s), 32'(DEPTH)) < 32'(level_s));
      addr_flat_s[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_mem_q[i];
      data_flat_s[i*DATA_WIDTH +: DATA_WIDTH] = data_mem_q[i];
    end
  end

  sram_wb_snoop #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_snoop (
    .occ_mask_i   (occ_mask_s),
    .addr_flat_i  (addr_flat_s),
    .data_flat_i  (data_flat_s),
    .newest_idx_i (newest_idx_s),
    .snoop_addr_i (snoop_addr),
    .hit_o        (snoop_hit),
    .data_o       (snoop_data)
  );

  assign full        = full_s;
  assign almost_full = (level_s >= (PW+1)'(AFULL_LEVEL));
  assign level       = level_s;
  assign overflow    = overflow_q;
  assign rd_valid    = valid_s;
  assign rd_addr     = addr_mem_q[rd_idx_s];
  assign rd_data     = data_mem_q[rd_idx_s];

endmodule

// File: tb/tb_sram_write_buffer.sv
module tb_sram_write_buffer;

  logic        clk;
  logic        reset;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        rd_en;
  logic [16:0] snoop_addr;

  logic        full, almost_full, overflow, rd_valid, snoop_hit;
  logic [4:0]  level;
  logic [16:0] rd_addr;
  logic [7:0]  rd_data, snoop_data;

  logic        n_full, n_afull, n_overflow, n_rd_valid, n_snoop_hit;
  logic [4:0]  n_level;
  logic [16:0] n_rd_addr;
  logic [7:0]  n_rd_data, n_snoop_data;

  int vectors;
  int miscompares;

  sram_write_buffer dut (
    .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .almost_full(almost_full), .level(level), .overflow(overflow),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data)
  );

  sram_write_buffer #(.COALESCE(0)) dut_nc (
    .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .full(n_full), .almost_full(n_afull), .level(n_level), .overflow(n_overflow),
    .rd_addr(n_rd_addr), .rd_data(n_rd_data), .rd_valid(n_rd_valid), .rd_en(rd_en),
    .snoop_addr(snoop_addr), .snoop_hit(n_snoop_hit), .snoop_data(n_snoop_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic we, input logic [16:0] a, input logic [7:0] d,
                       input logic re);
    wr_en = we; wr_addr = a; wr_data = d; rd_en = re;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle(1'b0, 17'h0, 8'h0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    snoop_addr = 17'h0;
    #1;
    vectors++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0 ||
        overflow !== 1'b0 || snoop_hit !== 1'b0 || snoop_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: level=%0d valid=%b full=%b af=%b ovf=%b hit=%b sd=%h, want 0s",
               level, rd_valid, full, almost_full, overflow, snoop_hit, snoop_data);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 17'h100 + 17'(i), 8'(i * 3 + 1), 1'b0);
      vectors++;
      if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || full !== (i == 15)) begin
        miscompares++;
        $display("FAIL fill[%0d]: level=%0d af=%b full=%b, want level=%0d af=%b full=%b",
                 i, level, almost_full, full, i + 1, (i + 1 >= 12), (i == 15));
      end
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_addr !== 17'h100 + 17'(i) || rd_data !== 8'(i * 3 + 1)) begin
        miscompares++;
        $display("FAIL drain[%0d]: valid=%b addr=%h data=%h, want 1 %h %h",
                 i, rd_valid, rd_addr, rd_data, 17'h100 + 17'(i), 8'(i * 3 + 1));
      end
      cycle(1'b0, 17'h0, 8'h0, 1'b1);
    end
    vectors++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL drain_empty: valid=%b level=%0d, want 0 0", rd_valid, level);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    cycle(1'b1, 17'h00010, 8'hAA, 1'b0);
    cycle(1'b1, 17'h00010, 8'hBB, 1'b0);
    vectors++;
    if (level !== 5'd1 || rd_data !== 8'hBB) begin
      miscompares++;
      $display("FAIL coalesce: level=%0d data=%h, want 1 bb", level, rd_data);
    end
    vectors++;
    if (n_level !== 5'd2 || n_rd_data !== 8'hAA) begin
      miscompares++;
      $display("FAIL no_coalesce: level=%0d data=%h, want 2 aa", n_level, n_rd_data);
    end
  endtask

  task automatic test_pop_race();
    do_reset();
    cycle(1'b1, 17'h00A0, 8'h01, 1'b0);
    cycle(1'b1, 17'h00A0, 8'h02, 1'b1);
    vectors++;
    if (level !== 5'd1 || rd_addr !== 17'h00A0 || rd_data !== 8'h02) begin
      miscompares++;
      $display("FAIL pop_race: level=%0d addr=%h data=%h, want 1 000a0 02",
               level, rd_addr, rd_data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 17'h200 + 17'(i), 8'(i), 1'b0);
    cycle(1'b1, 17'h20F, 8'h77, 1'b0);
    snoop_addr = 17'h20F;
    #1;
    vectors++;
    if (level !== 5'd16 || overflow !== 1'b0 || snoop_hit !== 1'b1 || snoop_data !== 8'h77) begin
      miscompares++;
      $display("FAIL full_coalesce: level=%0d ovf=%b hit=%b sd=%h, want 16 0 1 77",
               level, overflow, snoop_hit, snoop_data);
    end
    cycle(1'b1, 17'h300, 8'h55, 1'b1);
    vectors++;
    if (level !== 5'd15 || overflow !== 1'b1 || rd_addr !== 17'h201) begin
      miscompares++;
      $display("FAIL overflow: level=%0d ovf=%b head=%h, want 15 1 00201",
               level, overflow, rd_addr);
    end
  endtask

  task automatic test_snoop();
    do_reset();
    cycle(1'b1, 17'h5, 8'h11, 1'b0);
    cycle(1'b1, 17'h6, 8'h22, 1'b0);
    cycle(1'b1, 17'h5, 8'h33, 1'b0);
    snoop_addr = 17'h5;
    #1;
    vectors++;
    if (snoop_hit !== 1'b1 || snoop_data !== 8'h33 || level !== 5'd3) begin
      miscompares++;
      $display("FAIL snoop_hit: hit=%b data=%h level=%0d, want 1 33 3",
               snoop_hit, snoop_data, level);
    end
    snoop_addr = 17'h7;
    #1;
    vectors++;
    if (snoop_hit !== 1'b0 || snoop_data !== 8'h00) begin
      miscompares++;
      $display("FAIL snoop_miss: hit=%b data=%h, want 0 00", snoop_hit, snoop_data);
    end
  endtask

  task automatic test_wrap_random();
    logic [16:0] aq[$];
    logic [7:0]  dq[$];
    logic        ovf_m;
    logic        we, re, coal, full_m;
    logic [16:0] a;
    logic [7:0]  d;
    int          lvl;
    do_reset();
    ovf_m = 1'b0;
    for (int n = 0; n < 60; n++) begin
      we = ($urandom_range(0, 9) < 7);
      re = ($urandom_range(0, 9) < 5);
      a  = 17'($urandom_range(0, 5));
      d  = 8'($urandom_range(0, 255));
      lvl    = aq.size();
      full_m = (lvl == 16);
      coal   = we && lvl >= 1 && a == aq[lvl - 1] && !(lvl == 1 && re);
      if (coal) dq[lvl - 1] = d;
      if (re && lvl > 0) begin
        void'(aq.pop_front());
        void'(dq.pop_front());
      end
      if (we && !coal && !full_m) begin
        aq.push_back(a);
        dq.push_back(d);
      end
      if (we && !coal && full_m) ovf_m = 1'b1;
      cycle(we, a, d, re);
      vectors++;
      if (level !== 5'(aq.size()) || rd_valid !== (aq.size() > 0) || overflow !== ovf_m ||
          (aq.size() > 0 && (rd_addr !== aq[0] || rd_data !== dq[0]))) begin
        miscompares++;
        $display("FAIL random[%0d]: level=%0d valid=%b ovf=%b head=%h/%h, want level=%0d ovf=%b head=%h/%h",
                 n, level, rd_valid, overflow, rd_addr, rd_data, aq.size(), ovf_m,
                 (aq.size() > 0) ? aq[0] : 17'h0, (aq.size() > 0) ? dq[0] : 8'h0);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cycle(1'b1, 17'h40, 8'h01, 1'b0);
    cycle(1'b1, 17'h41, 8'h02, 1'b0);
    snoop_addr = 17'h40;
    #1;
    vectors++;
    if (snoop_hit !== 1'b1 || level !== 5'd2) begin
      miscompares++;
      $display("FAIL pre_reset: hit=%b level=%0d, want 1 2", snoop_hit, level);
    end
    reset = 1'b0;
    cycle(1'b1, 17'h42, 8'h03, 1'b1);
    reset = 1'b1;
    #1;
    vectors++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0 ||
        overflow !== 1'b0 || snoop_hit !== 1'b0 || snoop_data !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: level=%0d valid=%b full=%b af=%b ovf=%b hit=%b sd=%h, want 0s",
               level, rd_valid, full, almost_full, overflow, snoop_hit, snoop_data);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 17'h0; wr_data = 8'h0; snoop_addr = 17'h0;
    test_reset();
    test_fill_drain();
    test_coalesce();
    test_pop_race();
    test_overflow();
    test_snoop();
    test_wrap_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
